// File: rtl/color_match_ctrl_pkg.sv
// Shared types and constants for the colour-match controller slice.
package color_match_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   // Coordinate sums carry a full counter's worth of headroom above the coordinate.
   function automatic int sum_w(input int coord_w, input int cnt_w);
      return coord_w + cnt_w;
   endfunction

endpackage

// File: rtl/frame_accumulator.sv
// Per-frame match count and coordinate sums, snapshotted into result registers.
module frame_accumulator
   import color_match_ctrl_pkg::*;
#(
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int CNT_W = 20
) (
   input  logic                          clk_100M,
   input  logic                          rst_n,
   input  logic                          clr,
   input  logic                          add,
   input  logic                          snap,
   input  logic [X_W-1:0]                x,
   input  logic [Y_W-1:0]                y,
   output logic [CNT_W-1:0]              res_count,
   output logic [sum_w(X_W,CNT_W)-1:0]   res_sum_x,
   output logic [sum_w(Y_W,CNT_W)-1:0]   res_sum_y
);

   localparam int SX_W = sum_w(X_W, CNT_W);
   localparam int SY_W = sum_w(Y_W, CNT_W);

   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [SX_W-1:0]  sx, sx_nxt;
   logic [SY_W-1:0]  sy, sy_nxt;

   always_comb begin
      cnt_nxt = cnt;
      sx_nxt  = sx;
      sy_nxt  = sy;
      if (add) begin
         cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
         sx_nxt  = sx + SX_W'(x);
         sy_nxt  = sy + SY_W'(y);
      end
   end

   // The snapshot takes the next-state totals so the final beat of a frame is included.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sx        <= '0;
         sy        <= '0;
         res_count <= '0;
         res_sum_x <= '0;
         res_sum_y <= '0;
      end else begin
         if (clr) begin
            cnt <= '0;
            sx  <= '0;
            sy  <= '0;
         end else begin
            cnt <= cnt_nxt;
            sx  <= sx_nxt;
            sy  <= sy_nxt;
         end
         if (snap) begin
            res_count <= cnt_nxt;
            res_sum_x <= sx_nxt;
            res_sum_y <= sy_nxt;
         end
      end
   end

endmodule

// File: rtl/single_color_cmp.sv
// One colour channel comparator: registers |pix - target| and threshold on enable.
module single_color_cmp (
   input  logic       clk_100M,
   input  logic       rst_p,
   input  logic       en,
   input  logic [7:0] pix,
   input  logic [7:0] target,
   input  logic [7:0] thresh,
   output logic       match
);

   logic [7:0] diff_q;
   logic [7:0] thr_q;

   always_ff @(posedge clk_100M or posedge rst_p) begin
      if (rst_p) begin
         diff_q <= '0;
         thr_q  <= '0;
      end else if (en) begin
         diff_q <= (pix >= target) ? (pix - target) : (target - pix);
         thr_q  <= thresh;
      end
   end

   // Reset state 0 < 0 is false, so a reset comparator never reports a match.
   assign match = (diff_q < thr_q);

endmodule

// File: rtl/color_match_ctrl.sv
// Pixel-stream colour match sequencer: shadow config, R/G/B comparators, mask stream, frame totals.
//   state     | meaning
//   ST_IDLE   | between frames; apply pending config, drop stray beats, wait for s_sof
//   ST_ACTIVE | frame in progress; every accepted beat is compared and masked
//   ST_REPORT | one-cycle res_valid strobe with the frame totals
module color_match_ctrl
   import color_match_ctrl_pkg::*;
#(
   parameter int X_W   = 10,
   parameter int Y_W   = 10,
   parameter int CNT_W = 20
) (
   input  logic                          clk_100M,
   input  logic                          rst_n,
   input  logic [23:0]                   cfg_color,
   input  logic [23:0]                   cfg_thresh,
   input  logic                          cfg_wr,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [23:0]                   s_rgb,
   input  logic                          s_sof,
   input  logic                          s_eol,
   input  logic                          s_eof,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          m_mask,
   output logic [X_W-1:0]                m_x,
   output logic [Y_W-1:0]                m_y,
   output logic                          m_last,
   output logic                          res_valid,
   output logic [CNT_W-1:0]              res_count,
   output logic [sum_w(X_W,CNT_W)-1:0]   res_sum_x,
   output logic [sum_w(Y_W,CNT_W)-1:0]   res_sum_y,
   output logic                          busy
);

   state_t         state;
   logic           pending;
   logic [23:0]    pend_color, pend_thresh;
   logic [23:0]    act_color, act_thresh;
   logic [X_W-1:0] x_cnt;
   logic [Y_W-1:0] y_cnt;
   logic           eof_taken;

   logic           rst_p;
   logic           apply, accept, take_sof, cmp_en, m_hs;
   logic [X_W-1:0] pix_x;
   logic [Y_W-1:0] pix_y;
   logic           match_r, match_g, match_b;

   assign rst_p    = ~rst_n;
   assign apply    = (state == ST_IDLE) && pending;
   assign s_ready  = ((state == ST_ACTIVE) || ((state == ST_IDLE) && !pending))
                     && (!m_valid || m_ready) && !eof_taken;
   assign accept   = s_valid && s_ready;
   assign take_sof = accept && (state == ST_IDLE) && s_sof;
   assign cmp_en   = take_sof || (accept && (state == ST_ACTIVE));
   assign pix_x    = take_sof ? '0 : x_cnt;
   assign pix_y    = take_sof ? '0 : y_cnt;
   assign m_hs     = m_valid && m_ready;
   assign m_mask   = m_valid && match_r && match_g && match_b;
   assign busy     = (state != ST_IDLE);

   // A write coinciding with an apply must stay pending for the following frame.
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= 1'b0;
         pend_color  <= '0;
         pend_thresh <= '0;
         act_color   <= '0;
         act_thresh  <= '0;
      end else begin
         pending <= cfg_wr || (pending && !apply);
         if (cfg_wr) begin
            pend_color  <= cfg_color;
            pend_thresh <= cfg_thresh;
         end
         if (apply) begin
            act_color  <= pend_color;
            act_thresh <= pend_thresh;
         end
      end
   end

   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         x_cnt     <= '0;
         y_cnt     <= '0;
         eof_taken <= 1'b0;
         m_valid   <= 1'b0;
         m_x       <= '0;
         m_y       <= '0;
         m_last    <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         m_valid   <= cmp_en || (m_valid && !m_ready);
         if (cmp_en) begin
            m_x    <= pix_x;
            m_y    <= pix_y;
            m_last <= s_eof;
            x_cnt  <= s_eol ? '0 : pix_x + X_W'(1);
            y_cnt  <= s_eol ? pix_y + Y_W'(1) : pix_y;
            if (s_eof) eof_taken <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (take_sof) state <= ST_ACTIVE;
            end
            ST_ACTIVE: begin
               if (m_hs && m_last) begin
                  state     <= ST_REPORT;
                  res_valid <= 1'b1;
               end
            end
            ST_REPORT: begin
               state     <= ST_IDLE;
               eof_taken <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   single_color_cmp u_cmp_r (
      .clk_100M (clk_100M),
      .rst_p    (rst_p),
      .en       (cmp_en),
      .pix      (s_rgb[R_HI:R_LO]),
      .target   (act_color[R_HI:R_LO]),
      .thresh   (act_thresh[R_HI:R_LO]),
      .match    (match_r)
   );

   single_color_cmp u_cmp_g (
      .clk_100M (clk_100M),
      .rst_p    (rst_p),
      .en       (cmp_en),
      .pix      (s_rgb[G_HI:G_LO]),
      .target   (act_color[G_HI:G_LO]),
      .thresh   (act_thresh[G_HI:G_LO]),
      .match    (match_g)
   );

   single_color_cmp u_cmp_b (
      .clk_100M (clk_100M),
      .rst_p    (rst_p),
      .en       (cmp_en),
      .pix      (s_rgb[B_HI:B_LO]),
      .target   (act_color[B_HI:B_LO]),
      .thresh   (act_thresh[B_HI:B_LO]),
      .match    (match_b)
   );

   frame_accumulator #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .CNT_W (CNT_W)
   ) u_acc (
      .clk_100M  (clk_100M),
      .rst_n     (rst_n),
      .clr       (take_sof),
      .add       (m_hs && m_mask),
      .snap      (m_hs && m_last),
      .x         (m_x),
      .y         (m_y),
      .res_count (res_count),
      .res_sum_x (res_sum_x),
      .res_sum_y (res_sum_y)
   );

endmodule

// File: tb/tb_color_match_ctrl.sv
// Scoreboard bench for color_match_ctrl: expected beats/totals queued at drive time, checked at output.
module tb_color_match_ctrl;

   localparam int X_W   = 10;
   localparam int Y_W   = 10;
   localparam int CNT_W = 20;

   logic                  clk_100M = 1'b0;
   logic                  rst_n = 1'b0;
   logic [23:0]           cfg_color = '0, cfg_thresh = '0;
   logic                  cfg_wr = 1'b0;
   logic                  s_valid = 1'b0, s_ready;
   logic [23:0]           s_rgb = '0;
   logic                  s_sof = 1'b0, s_eol = 1'b0, s_eof = 1'b0;
   logic                  m_valid, m_ready = 1'b1, m_mask, m_last;
   logic [X_W-1:0]        m_x;
   logic [Y_W-1:0]        m_y;
   logic                  res_valid, busy;
   logic [CNT_W-1:0]      res_count;
   logic [X_W+CNT_W-1:0]  res_sum_x;
   logic [Y_W+CNT_W-1:0]  res_sum_y;

   color_match_ctrl #(.X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W)) dut (
      .clk_100M (clk_100M), .rst_n (rst_n),
      .cfg_color (cfg_color), .cfg_thresh (cfg_thresh), .cfg_wr (cfg_wr),
      .s_valid (s_valid), .s_ready (s_ready), .s_rgb (s_rgb),
      .s_sof (s_sof), .s_eol (s_eol), .s_eof (s_eof),
      .m_valid (m_valid), .m_ready (m_ready), .m_mask (m_mask),
      .m_x (m_x), .m_y (m_y), .m_last (m_last),
      .res_valid (res_valid), .res_count (res_count),
      .res_sum_x (res_sum_x), .res_sum_y (res_sum_y), .busy (busy)
   );

   always #5 clk_100M = ~clk_100M;

   typedef struct packed {
      logic           mask;
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           last;
   } beat_t;

   typedef struct packed {
      logic [CNT_W-1:0]     cnt;
      logic [X_W+CNT_W-1:0] sx;
      logic [Y_W+CNT_W-1:0] sy;
   } res_t;

   beat_t       beat_q[$];
   res_t        res_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   logic [23:0] act_c, act_t, pend_c, pend_t;
   bit          pend_f;
   int          a_cnt, a_sx, a_sy;
   logic [23:0] pix [0:63];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit ch_match(input logic [7:0] p, input logic [7:0] t, input logic [7:0] th);
      int d;
      d = int'(p) - int'(t);
      if (d < 0) d = -d;
      return d < int'(th);
   endfunction

   function automatic bit px_match(input logic [23:0] rgb);
      logic [23:0] c, t;
      c = act_c;
      t = act_t;
      return ch_match(rgb[23:16], c[23:16], t[23:16]) &&
             ch_match(rgb[15:8],  c[15:8],  t[15:8])  &&
             ch_match(rgb[7:0],   c[7:0],   t[7:0]);
   endfunction

   always @(negedge clk_100M) begin
      if (rst_n) begin
         if (m_valid && m_ready) begin
            if (beat_q.size() == 0) chk("beat_q_depth", 64'(beat_q.size()), 64'd1);
            else begin
               beat_t e;
               e = beat_q.pop_front();
               chk("m_mask", 64'(m_mask), 64'(e.mask));
               chk("m_x",    64'(m_x),    64'(e.x));
               chk("m_y",    64'(m_y),    64'(e.y));
               chk("m_last", 64'(m_last), 64'(e.last));
            end
         end
         if (res_valid) begin
            if (res_q.size() == 0) chk("res_q_depth", 64'(res_q.size()), 64'd1);
            else begin
               res_t r;
               r = res_q.pop_front();
               chk("res_count", 64'(res_count), 64'(r.cnt));
               chk("res_sum_x", 64'(res_sum_x), 64'(r.sx));
               chk("res_sum_y", 64'(res_sum_y), 64'(r.sy));
            end
         end
      end
   end

   task automatic send_pix(input logic [23:0] rgb, input bit sof, input bit eol, input bit eof,
                           input bit push, input int x, input int y);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      s_valid = 1'b1; s_rgb = rgb; s_sof = sof; s_eol = eol; s_eof = eof;
      while (!ok && n < 50) begin
         @(negedge clk_100M);
         if (s_ready) ok = 1'b1;
         n++;
      end
      if (!ok) chk("s_ready_wait", 64'(ok), 64'd1);
      if (ok && push) begin
         beat_t b;
         b.mask = px_match(rgb);
         b.x    = X_W'(x);
         b.y    = Y_W'(y);
         b.last = eof;
         beat_q.push_back(b);
         if (b.mask) begin
            a_cnt++; a_sx += x; a_sy += y;
         end
         if (eof) begin
            res_t r;
            r.cnt = CNT_W'(a_cnt);
            r.sx  = (X_W+CNT_W)'(a_sx);
            r.sy  = (Y_W+CNT_W)'(a_sy);
            res_q.push_back(r);
         end
      end
      @(posedge clk_100M); #1;
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_eof = 1'b0;
   endtask

   task automatic begin_frame();
      if (pend_f) begin
         act_c  = pend_c;
         act_t  = pend_t;
         pend_f = 1'b0;
      end
      a_cnt = 0; a_sx = 0; a_sy = 0;
   endtask

   task automatic send_frame(input int w, input int h);
      begin_frame();
      for (int yy = 0; yy < h; yy++)
         for (int xx = 0; xx < w; xx++)
            send_pix(pix[yy*w+xx], (yy == 0 && xx == 0), (xx == w-1),
                     (yy == h-1 && xx == w-1), 1'b1, xx, yy);
      for (int i = 0; i < 20 && res_q.size() != 0; i++) @(posedge clk_100M);
      #1;
      if (res_q.size() != 0) chk("res_wait", 64'(res_q.size()), 64'd0);
   endtask

   task automatic write_cfg(input logic [23:0] c, input logic [23:0] t, input bit bubble);
      cfg_color = c; cfg_thresh = t; cfg_wr = 1'b1;
      @(posedge clk_100M); #1;
      cfg_wr = 1'b0;
      pend_c = c; pend_t = t; pend_f = 1'b1;
      if (bubble) begin
         @(negedge clk_100M);
         chk("cfg_bubble_s_ready", 64'(s_ready), 64'd0);
         @(posedge clk_100M); #1;
         @(negedge clk_100M);
         chk("post_apply_s_ready", 64'(s_ready), 64'd1);
         @(posedge clk_100M); #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_eof = 1'b0; cfg_wr = 1'b0;
      beat_q.delete();
      res_q.delete();
      act_c = '0; act_t = '0; pend_c = '0; pend_t = '0; pend_f = 1'b0;
      #2;
      chk("rst_m_valid",   64'(m_valid),   64'd0);
      chk("rst_m_mask",    64'(m_mask),    64'd0);
      chk("rst_m_xy",      64'({m_x, m_y, m_last}), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_res",       64'({res_count, res_sum_x[9:0]}) | 64'(res_sum_y), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_s_ready",   64'(s_ready),   64'd1);
      repeat (2) @(posedge clk_100M);
      #1 rst_n = 1'b1;
      @(posedge clk_100M); #1;
   endtask

   task automatic stall3();
      logic [X_W-1:0] hx;
      logic           hm;
      int             n;
      n = 0;
      while (!m_valid && n < 50) begin
         @(negedge clk_100M);
         n++;
      end
      @(posedge clk_100M); #1;
      m_ready = 1'b0;
      @(negedge clk_100M);
      chk("stall_m_valid", 64'(m_valid), 64'd1);
      hx = m_x;
      hm = m_mask;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_100M);
         chk("stall_m_x",     64'(m_x),     64'(hx));
         chk("stall_m_mask",  64'(m_mask),  64'(hm));
         chk("stall_s_ready", 64'(s_ready), 64'd0);
      end
      @(posedge clk_100M); #1;
      m_ready = 1'b1;
   endtask

   task automatic fill_frame_a();
      for (int i = 0; i < 64; i++) pix[i] = 24'h0;
      pix[1*4+2] = {8'd205, 8'd45, 8'd50};
   endtask

   initial begin
      #1;
      do_reset();

      write_cfg({8'd200, 8'd50, 8'd50}, {3{8'd10}}, 1'b1);

      // stray beats before any s_sof
      send_pix({8'd200, 8'd50, 8'd50}, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      send_pix({8'd205, 8'd45, 8'd50}, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      @(negedge clk_100M);
      chk("stray_busy", 64'(busy), 64'd0);
      @(posedge clk_100M); #1;

      fill_frame_a();
      send_frame(4, 2);

      pix[0] = {8'd210, 8'd50, 8'd50};
      pix[1] = {8'd209, 8'd50, 8'd50};
      send_frame(2, 1);

      fill_frame_a();
      fork
         send_frame(4, 2);
         begin
            repeat (2) @(posedge clk_100M);
            #1 stall3();
         end
      join

      fill_frame_a();
      fork
         send_frame(4, 2);
         begin
            repeat (3) @(posedge clk_100M);
            #1 write_cfg(24'h000000, {3{8'd5}}, 1'b0);
         end
      join
      send_frame(4, 2);

      pix[0] = 24'h020301;
      send_frame(1, 1);

      fill_frame_a();
      begin_frame();
      for (int i = 0; i < 3; i++)
         send_pix(pix[i], (i == 0), 1'b0, 1'b0, 1'b1, i, 0);
      do_reset();

      send_frame(4, 2);
      write_cfg({8'd200, 8'd50, 8'd50}, {3{8'd10}}, 1'b1);
      send_frame(4, 2);

      repeat (10) @(posedge clk_100M);
      #1;
      chk("beat_q_left", 64'(beat_q.size()), 64'd0);
      chk("res_q_left",  64'(res_q.size()),  64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_err=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/color_match_ctrl.md
# color_match_ctrl

Sequencing controller for the per-channel colour comparators in the ball locator. It accepts a raster pixel stream, drives three `single_color_cmp` instances (R, G, B) with a shared enable, and aligns their one-cycle-late results into a per-pixel match-mask stream. It holds target colour and thresholds in shadow registers that change only between frames. Per frame it accumulates match count and coordinate sums for the centroid stage downstream.

## Interface
- `X_W`, default 10: x coordinate width.
- `Y_W`, default 10: y coordinate width.
- `CNT_W`, default 20: match counter width.
- `clk_100M` in 1: system clock. All logic runs on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cfg_color` in 24: pending target colour, {R,G,B}.
- `cfg_thresh` in 24: pending per-channel thresholds, {R,G,B}.
- `cfg_wr` in 1: single-cycle pulse that latches `cfg_*` into the pending registers.
- `s_valid` / `s_ready` in / out 1: pixel handshake.
- `s_rgb` in 24: pixel colour.
- `s_sof` in 1: first pixel of a frame.
- `s_eol` in 1: last pixel of a line.
- `s_eof` in 1: last pixel of a frame.
- `m_valid` / `m_ready` out / in 1: mask handshake.
- `m_mask` out 1: 1 when all three channels match.
- `m_x` out X_W, `m_y` out Y_W: coordinates of the masked pixel.
- `m_last` out 1: mask beat belongs to the `s_eof` pixel.
- `res_valid` out 1: single-cycle frame result strobe.
- `res_count` out CNT_W: number of matched pixels in the frame.
- `res_sum_x` out X_W+CNT_W, `res_sum_y` out Y_W+CNT_W: coordinate sums of the matched pixels.
- `busy` out 1: high when the state is not IDLE.

## Operation
- **FSM states:** IDLE, ACTIVE, REPORT.
- **IDLE:**
  - If a config is pending: copy pending to active, clear the pending flag, and force `s_ready`=0 for that one cycle.
  - Otherwise, beats without `s_sof` are accepted and dropped: comparators are not enabled and no mask beat is produced.
  - An accepted `s_sof` beat clears the accumulators, is compared at x=0, y=0, and moves the FSM to ACTIVE.
- **ACTIVE:**
  - Every accepted beat pulses the comparator enable (`en = s_valid & s_ready`).
  - x increments on each accepted beat. On `s_eol`, x returns to 0 and y increments.
  - `s_sof` is ignored in ACTIVE.
  - After the accepted `s_eof` beat, no more pixels are accepted until REPORT is done.
- **Mask:**
  - `m_mask` is the AND of the three comparator bits.
  - A channel matches when |pixel − target| < threshold (strict). Threshold 0 never matches.
- **Accumulate:** on each mask handshake with `m_mask`=1, `count++` (saturates at all-ones), `sum_x += x`, `sum_y += y`. The sums are sized so they cannot overflow.
- **REPORT:**
  - Entered on the handshake of the `m_last` beat.
  - `res_valid`=1 for exactly one cycle, with totals that include that last beat. Then return to IDLE.
  - The `res_*` outputs hold their values until the next REPORT.
- **Config write:** `cfg_wr` at any time overwrites the pending registers. The active config is never changed outside IDLE, so a write mid-frame takes effect from the next frame.
- **`s_ready`:** `(state==ACTIVE || (state==IDLE && !pending)) && (!m_valid || m_ready) && !eof_taken`.
- **Stall:** while the enable is low, the comparator difference registers hold, so `m_mask` stays stable under backpressure.

## Timing
- **Reset values:**
  - All outputs are 0 except `s_ready`, which is 1.
  - Active and pending config are cleared (thresholds 0, so nothing matches).
  - State goes to IDLE; accumulators and coordinates are cleared.
  - The comparators are reset through `rst_p = !rst_n`.
- **Latency:** pixel accepted at cycle T produces `m_valid` at T+1. `res_valid` comes 1 cycle after the `m_last` handshake.
- **Throughput:** 1 pixel per cycle while `m_ready`=1. A config apply costs exactly one bubble in IDLE.
- **Single-pixel frame** (`s_sof` and `s_eof` on the same beat): ACTIVE is entered and left immediately; the frame is reported normally.
- **Reset mid-frame:** no `res_valid`, the partial frame is discarded, and the next `s_sof` starts clean.
- **Comparator reset state:** the comparators' reset output is never qualified as a mask beat.

## Structure
- A shared package holds:
  - the FSM state enum;
  - RGB channel slice constants (R=[23:16], G=[15:8], B=[7:0]);
  - the result width expressions.
- One natural sub-module, `frame_accumulator`: count and sums with saturate and clear.
- The controller instantiates three `single_color_cmp` instances plus `frame_accumulator`.

## Test plan
- **Reset:** assert `rst_n`=0 during a frame → all outputs 0, `s_ready`=1, no `res_valid`. Next full frame reports correctly.
- **Single match:** target (200,50,50), thresholds (10,10,10). 4×2 frame, pixel (205,45,50) at x=2, y=1, all others (0,0,0) → exactly one `m_mask`=1, then `res_count`=1, `res_sum_x`=2, `res_sum_y`=1.
- **Boundary:** same config, pixel (210,50,50) → `m_mask`=0 (diff equals threshold). Pixel (209,50,50) → 1.
- **Backpressure:** `m_ready` low for 3 cycles mid-line → `m_mask`/`m_x` stable, `s_ready`=0, no beat lost or duplicated, totals unchanged versus the no-stall run.
- **Config mid-frame:** `cfg_wr` during ACTIVE → current frame uses the old config, one IDLE bubble, next frame uses the new config.
- **Stray pixels:** beats before any `s_sof` → accepted, no `m_valid`, no accumulation.
